// File: rtl/sp_pkg.sv
// Shared types and constants for the sub-pixel interpolator front end.
// win_bit_lsb() is the single source of truth for pixel placement in a window word.
package sp_pkg;
   localparam int PIX_W   = 8;
   localparam int WIN_DIM = 8;
   localparam int WIN_PIX = WIN_DIM * WIN_DIM;
   localparam int IDX_W   = $clog2(WIN_PIX);

   typedef logic [PIX_W-1:0]         pix_t;
   typedef logic [WIN_PIX*PIX_W-1:0] win_t;
   typedef logic [IDX_W-1:0]         idx_t;

   // c = column 1..WIN_DIM, r = row 1..WIN_DIM; raster order, column fastest
   function automatic int win_bit_lsb(input int c, input int r);
      return ((r - 1) * WIN_DIM + (c - 1)) * PIX_W;
   endfunction
endpackage

// File: rtl/sp_win_bank.sv
// One 8x8 window of pixel registers: indexed single-pixel write, whole-window flat read.
module sp_win_bank
   import sp_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_we,
   input  logic [IDX_W-1:0] i_idx,
   input  logic [PIX_W-1:0] i_pix,
   output logic [WIN_PIX*PIX_W-1:0] o_win
);

   pix_t [WIN_PIX-1:0] r_mem;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem <= '0;
      end else if (i_we) begin
         r_mem[i_idx] <= i_pix;
      end
   end

   assign o_win = r_mem;

endmodule

// File: rtl/sp_window_loader.sv
// Raster pixel stream to 8x8 window assembler with two ping-ponged banks:
// one bank fills while the other is held for the consumer.
module sp_window_loader
   import sp_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [PIX_W-1:0]         pix_in,
   input  logic                     pix_valid,
   input  logic                     pix_sof,
   output logic                     pix_ready,
   output logic [WIN_PIX*PIX_W-1:0] win_data,
   output logic                     win_valid,
   input  logic                     win_ready,
   output logic                     sof_err
);

   logic       r_wr_bank;
   logic       r_rd_bank;
   idx_t       r_wr_idx;
   logic [1:0] r_full;
   logic       r_sof_err;

   logic       w_pix_xfer;
   logic       w_win_xfer;
   logic       w_last;
   idx_t       w_wr_addr;
   logic [1:0] w_we;
   logic [1:0] w_full_nxt;
   win_t       w_bank0;
   win_t       w_bank1;

   // Ready depends only on registered flags, never on win_ready
   assign pix_ready  = !r_full[r_wr_bank];
   assign win_valid  = r_full[r_rd_bank];
   assign w_pix_xfer = pix_valid && pix_ready;
   assign w_win_xfer = win_valid && win_ready;

   // SOF restarts the window, so it overrides a would-be last pixel
   assign w_last     = !pix_sof && (r_wr_idx == idx_t'(WIN_PIX - 1));
   assign w_wr_addr  = pix_sof ? '0 : r_wr_idx;
   assign w_we[0]    = w_pix_xfer && !r_wr_bank;
   assign w_we[1]    = w_pix_xfer &&  r_wr_bank;

   sp_win_bank u_bank0 (
      .clk   (clk),
      .rst_n (rst_n),
      .i_we  (w_we[0]),
      .i_idx (w_wr_addr),
      .i_pix (pix_in),
      .o_win (w_bank0)
   );

   sp_win_bank u_bank1 (
      .clk   (clk),
      .rst_n (rst_n),
      .i_we  (w_we[1]),
      .i_idx (w_wr_addr),
      .i_pix (pix_in),
      .o_win (w_bank1)
   );

   assign win_data = r_rd_bank ? w_bank1 : w_bank0;
   assign sof_err  = r_sof_err;

   // Set and clear always target different banks: a full bank is never written
   always_comb begin
      w_full_nxt = r_full;
      if (w_pix_xfer && w_last) begin
         w_full_nxt[r_wr_bank] = 1'b1;
      end
      if (w_win_xfer) begin
         w_full_nxt[r_rd_bank] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_bank <= 1'b0;
         r_rd_bank <= 1'b0;
         r_wr_idx  <= '0;
         r_full    <= '0;
         r_sof_err <= 1'b0;
      end else begin
         r_full    <= w_full_nxt;
         r_sof_err <= w_pix_xfer && pix_sof && (r_wr_idx != '0);
         if (w_win_xfer) begin
            r_rd_bank <= !r_rd_bank;
         end
         if (w_pix_xfer) begin
            if (pix_sof) begin
               r_wr_idx <= idx_t'(1);
            end else if (w_last) begin
               r_wr_bank <= !r_wr_bank;
               r_wr_idx  <= '0;
            end else begin
               r_wr_idx <= r_wr_idx + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sp_window_loader.sv
// Directed bench for sp_window_loader: fill, backpressure, streaming, SOF restart, async reset.
module tb_sp_window_loader;
   import sp_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [7:0]   pix_in = '0;
   logic         pix_valid = 1'b0;
   logic         pix_sof = 1'b0;
   logic         pix_ready;
   logic [511:0] win_data;
   logic         win_valid;
   logic         win_ready = 1'b0;
   logic         sof_err;

   int n_checks = 0;
   int n_errs   = 0;
   int n_stall  = 0;
   int n_xfer   = 0;
   logic mon_en = 1'b0;
   logic [511:0] exp_win;

   sp_window_loader dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pix_in    (pix_in),
      .pix_valid (pix_valid),
      .pix_sof   (pix_sof),
      .pix_ready (pix_ready),
      .win_data  (win_data),
      .win_valid (win_valid),
      .win_ready (win_ready),
      .sof_err   (sof_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      pix_valid = 1'b0;
      pix_sof = 1'b0;
      win_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Present one pixel and hold it until it is accepted on a rising edge
   task automatic push(input logic [7:0] v, input logic sof);
      int n = 0;
      pix_in = v;
      pix_sof = sof;
      pix_valid = 1'b1;
      if (!pix_ready) n_stall++;
      while (!pix_ready && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 200) chk("push_timeout_ready", {511'b0, pix_ready}, 512'd1);
      @(posedge clk);
      #1;
      pix_valid = 1'b0;
      pix_sof = 1'b0;
   endtask

   task automatic pulse_win();
      win_ready = 1'b1;
      @(posedge clk);
      #1;
      win_ready = 1'b0;
   endtask

   function automatic logic [7:0] pix_at(input logic [511:0] w, input int c, input int r);
      return w[win_bit_lsb(c, r) +: 8];
   endfunction

   // Streaming checker: looks at each window on the cycle it is being consumed
   always @(negedge clk) begin
      if (mon_en && win_valid && win_ready) begin
         n_xfer++;
         for (int c = 1; c <= 8; c++) chk("stream_row4", {504'b0, pix_at(win_data, c, 4)}, 512'(c));
         chk("stream_I11", {504'b0, pix_at(win_data, 1, 1)}, 512'd10);
         chk("stream_I88", {504'b0, pix_at(win_data, 8, 8)}, 512'd10);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state and a single constant window
      do_reset();
      chk("rst_pix_ready", {511'b0, pix_ready}, 512'd1);
      chk("rst_win_valid", {511'b0, win_valid}, 512'd0);
      chk("rst_win_data", win_data, 512'd0);
      chk("rst_sof_err", {511'b0, sof_err}, 512'd0);
      for (int k = 0; k < 63; k++) push(8'd10, 1'b0);
      chk("fill63_win_valid", {511'b0, win_valid}, 512'd0);
      push(8'd10, 1'b0);
      chk("fill64_win_valid", {511'b0, win_valid}, 512'd1);
      chk("fill64_win_data", win_data, {64{8'h0A}});
      chk("fill64_pix_ready", {511'b0, pix_ready}, 512'd1);

      // Both banks full, then one consume
      do_reset();
      for (int k = 0; k < 128; k++) push(8'(k), 1'b0);
      chk("both_full_pix_ready", {511'b0, pix_ready}, 512'd0);
      chk("both_full_win_valid", {511'b0, win_valid}, 512'd1);
      for (int k = 0; k < 64; k++) exp_win[k*8 +: 8] = 8'(k);
      chk("win0_data", win_data, exp_win);
      chk("win0_I32", {504'b0, pix_at(win_data, 3, 2)}, 512'd10);
      pulse_win();
      chk("after_xfer_pix_ready", {511'b0, pix_ready}, 512'd1);
      chk("after_xfer_win_valid", {511'b0, win_valid}, 512'd1);
      for (int k = 0; k < 64; k++) exp_win[k*8 +: 8] = 8'(k + 64);
      chk("win1_data", win_data, exp_win);
      chk("win1_I11", {504'b0, pix_at(win_data, 1, 1)}, 512'd64);

      // Sustained streaming with an always-ready consumer
      do_reset();
      n_stall = 0;
      n_xfer = 0;
      win_ready = 1'b1;
      mon_en = 1'b1;
      for (int w = 0; w < 5; w++)
         for (int k = 0; k < 64; k++)
            push((k >= 24 && k < 32) ? 8'(k - 23) : 8'd10, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      mon_en = 1'b0;
      win_ready = 1'b0;
      chk("stream_xfers", 512'(n_xfer), 512'd5);
      chk("stream_stalls", 512'(n_stall), 512'd0);
      chk("stream_drained", {511'b0, win_valid}, 512'd0);

      // SOF restart mid-window
      do_reset();
      push(8'd1, 1'b1);
      chk("sof_at_idx0_err", {511'b0, sof_err}, 512'd0);
      for (int k = 1; k < 20; k++) push(8'd1, 1'b0);
      chk("pre_sof_err", {511'b0, sof_err}, 512'd0);
      push(8'h55, 1'b1);
      chk("sof_err_pulse", {511'b0, sof_err}, 512'd1);
      push(8'd2, 1'b0);
      chk("sof_err_clear", {511'b0, sof_err}, 512'd0);
      for (int k = 0; k < 61; k++) push(8'd2, 1'b0);
      chk("sof_62_win_valid", {511'b0, win_valid}, 512'd0);
      push(8'd2, 1'b0);
      chk("sof_63_win_valid", {511'b0, win_valid}, 512'd1);
      chk("sof_I11", {504'b0, pix_at(win_data, 1, 1)}, 512'h55);
      chk("sof_I21", {504'b0, pix_at(win_data, 2, 1)}, 512'd2);
      chk("sof_I88", {504'b0, pix_at(win_data, 8, 8)}, 512'd2);

      // Asynchronous reset while one window is held and another is filling
      do_reset();
      for (int k = 0; k < 64; k++) push(8'd7, 1'b0);
      for (int k = 0; k < 30; k++) push(8'd9, 1'b0);
      chk("held_win_valid", {511'b0, win_valid}, 512'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_win_valid", {511'b0, win_valid}, 512'd0);
      chk("async_rst_win_data", win_data, 512'd0);
      chk("async_rst_pix_ready", {511'b0, pix_ready}, 512'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 64; k++) push(8'd3, 1'b0);
      chk("post_rst_win_valid", {511'b0, win_valid}, 512'd1);
      chk("post_rst_win_data", win_data, {64{8'h03}});
      pulse_win();
      chk("post_rst_only_one", {511'b0, win_valid}, 512'd0);
      chk("post_rst_pix_ready", {511'b0, pix_ready}, 512'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end

endmodule

// File: doc/sp_window_loader.md
# sp_window_loader

Streaming front end for `sp_interpolator`. It accepts 8-bit luma pixels one per cycle in raster order over a valid/ready handshake and assembles them into a complete 8×8 window. It presents the window as a flat 512-bit word with a valid/ready handshake to the wrapper that drives the interpolator's `I11..I88` inputs. Two window banks are ping-ponged, so one bank fills while the other is held for the consumer.

## Interface
- `PIX_W`, 8, pixel width in bits; must stay 8 to match `sp_interpolator`.
- `WIN_DIM`, 8, window edge in pixels; must stay 8, giving `WIN_PIX` = 64.

- `clk`  in  1  single clock; all state is updated on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pix_in`  in  8  incoming pixel.
- `pix_valid`  in  1  `pix_in` is valid.
- `pix_sof`  in  1  qualifies `pix_in` as the first pixel of a window (index 0).
- `pix_ready`  out  1  loader can accept a pixel this cycle.
- `win_data`  out  512  window; pixel `I<c><r>` (c = column 1..8, r = row 1..8) sits at bits `[((r-1)*8+(c-1))*8 +: 8]`.
- `win_valid`  out  1  `win_data` holds a complete window.
- `win_ready`  in  1  consumer accepts the window.
- `sof_err`  out  1  one-cycle pulse: `pix_sof` accepted while a window was partially filled.

## Operation
- Pixel arrival order is raster, column fastest: index k = (r-1)*8 + (c-1).
- A pixel transfer occurs when `pix_valid && pix_ready`. A window transfer occurs when `win_valid && win_ready`.
- State registers:
  - `wr_bank` (1 bit) and `wr_idx` (6 bits): the fill position.
  - `rd_bank` (1 bit): the bank being presented.
  - `full[1:0]`: one flag per bank.
- `pix_ready = !full[wr_bank]`.
- On a pixel transfer, `pix_in` is written to `bank[wr_bank][wr_idx]`, then:
  - if `pix_sof`: the write goes to index 0 instead and `wr_idx` becomes 1. The partial window is discarded (old contents at other indices are overwritten by later pixels). `sof_err` pulses if `wr_idx != 0`.
  - if the write lands on index 63: `full[wr_bank]` is set, `wr_bank` toggles and `wr_idx` wraps to 0.
  - otherwise `wr_idx` increments.
- `win_valid = full[rd_bank]`.
- `win_data` is a mux of `bank[rd_bank]`. It stays stable while `win_valid` is high and the transfer has not yet occurred.
- On a window transfer, `full[rd_bank]` is cleared and `rd_bank` toggles.
- Per-bank state sequence is EMPTY → FILLING → FULL → EMPTY. A bank is never written while its full flag is set.
- Simultaneous events:
  - Completing one bank's fill and consuming the other bank in the same cycle: both updates apply. Flags are independent per bank.
  - `pix_sof` on the pixel that would also be index 63: `pix_sof` wins (write goes to index 0).
- `pix_valid` low: no state change. A pixel gap of any length is legal.

## Timing
- Reset (asynchronous assert, synchronous-edge release) sets:
  - `wr_bank`, `rd_bank`, `wr_idx`, `full` to 0;
  - all bank storage to 0;
  - `win_data` = 0, `win_valid` = 0, `sof_err` = 0;
  - `pix_ready` = 1 once flags are clear.
- Reset asserted mid-fill or mid-hold discards all windows. No partial window survives.
- Latency: 64th pixel accepted at edge N → `win_valid` = 1 and `win_data` valid in the cycle after edge N.
- Throughput: one pixel per cycle sustained when the consumer accepts each window within 64 cycles of it appearing.
- With both banks full: `pix_ready` = 0 until the first window transfer. It returns to 1 in the cycle after that transfer.
- `sof_err` is registered: high for exactly one cycle after the offending transfer edge.
- No combinational path from `win_ready` to `pix_ready`.

## Structure
- Shared package `sp_pkg` holds:
  - `PIX_W`, `WIN_DIM`, `WIN_PIX`;
  - typedef `pix_t` (8 bits) and typedef `win_t` (512 bits);
  - function `win_bit_lsb(c, r)` returning the LSB position of a pixel; the interpolator wrapper uses the same function.
- Sub-module `sp_win_bank`: 64×8 register bank with async-reset clear, a write enable and 6-bit write index, and a flat 512-bit read port. It is instantiated twice; the top module holds the pointers, flags and output mux.

## Test plan
- Reset release → `pix_ready` = 1, `win_valid` = 0, `win_data` = 0. Feed 64 pixels of value 10 back-to-back with `win_ready` = 0 → `win_valid` rises exactly one cycle after the 64th pixel, and every byte of `win_data` is 0x0A.
- Feed 128 pixels with `win_ready` held 0 → `pix_ready` drops after pixel 128. Pulse `win_ready` once → the first window (values 0..63 in raster order) transfers, `pix_ready` = 1 the next cycle, and the second window (64..127) is presented.
- Stream 5 windows back-to-back with `win_ready` = 1 constantly → no `pix_ready` deassertion, 5 window transfers, each window's `I14..I84` row bytes read 1..8 when stimulated with the row-4 pattern 1..8 and all other pixels 10.
- Send 20 pixels, then a pixel 0x55 with `pix_sof` = 1 → `sof_err` pulses once. 63 more pixels complete the window, and `I11` = 0x55.
- Assert `rst_n` = 0 after 30 pixels of the second window while the first window is held → `win_valid` = 0 and `win_data` = 0 immediately (asynchronous). After release, a fresh 64-pixel fill produces only that window.
